punc_control_fsm: RTL

//  Multi-cycle LC3 control unit for the PUnC processor; sits directly upstream of the datapath.

---
 rtl/punc_control_fsm.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/punc_control_fsm.sv
// PUnC LC3 multi-cycle control unit.
// Moore FSM with registered control strobes and NZP/halt state.
module punc_control_fsm #(
  parameter logic [2:0] RESET_NZP = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [15:0] rf_w_data,
  output logic        ir_ld,
  output logic        pc_clr,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [1:0]  pc_ld_sel,
  output logic [1:0]  mem_addr_sel,
  output logic        ind_ld,
  output logic        mem_w_en,
  output logic        rf_w_en,
  output logic        rf_w_addr_sel,
  output logic [1:0]  rf_w_data_sel,
  output logic        rf_r0_addr_sel,
  output logic        rf_r1_addr_sel,
  output logic [1:0]  alu_sel,
  output logic [2:0]  nzp,
  output logic        halted
);

  typedef enum logic [2:0] {
    INIT, FETCH, DECODE, EXEC, IND, HALT
  } state_t;

  typedef struct packed {
    logic       ir_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic       pc_ld;
    logic [1:0] pc_ld_sel;
    logic [1:0] mem_addr_sel;
    logic       ind_ld;
    logic       mem_w_en;
    logic       rf_w_en;
    logic       rf_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_r0_addr_sel;
    logic       rf_r1_addr_sel;
    logic [1:0] alu_sel;
    logic       halted;
  } ctrl_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;
  localparam logic [3:0] OP_TRP = 4'b1111;

  state_t state;
  state_t nxt;
  ctrl_t  ctrl;
  logic [3:0] op;

  assign op = ir[15:12];

  // Offsets are consumed by the datapath, not here.
  logic unused_ir;
  assign unused_ir = ^ir[8:0];

  function automatic ctrl_t dec(state_t s, logic [15:0] i,
                                logic [2:0] cc);
    ctrl_t c;
    c = '0;
    case (s)
      INIT:  c.pc_clr = 1'b1;
      FETCH: begin
        c.ir_ld  = 1'b1;
        c.pc_inc = 1'b1;
      end
      EXEC: begin
        case (i[15:12])
          OP_ADD, OP_AND, OP_NOT: begin
            c.rf_w_en = 1'b1;
            c.alu_sel = (i[15:12] == OP_ADD) ? 2'd0 :
                        (i[15:12] == OP_AND) ? 2'd1 : 2'd2;
          end
          OP_LD, OP_LDR: begin
            c.mem_addr_sel  = (i[15:12] == OP_LD) ? 2'd1 : 2'd2;
            c.rf_w_data_sel = 2'd1;
            c.rf_w_en       = 1'b1;
          end
          OP_LEA: begin
            c.rf_w_data_sel = 2'd3;
            c.rf_w_en       = 1'b1;
          end
          OP_ST, OP_STR: begin
            c.mem_addr_sel   = (i[15:12] == OP_ST) ? 2'd1 : 2'd2;
            c.rf_r0_addr_sel = 1'b1;
            c.mem_w_en       = 1'b1;
          end
          OP_LDI, OP_STI: begin
            c.mem_addr_sel = 2'd1;
            c.ind_ld       = 1'b1;
          end
          OP_BR:  c.pc_ld = |(i[11:9] & cc);
          OP_JMP: begin
            c.pc_ld     = 1'b1;
            c.pc_ld_sel = 2'd2;
          end
          // Link and jump share the cycle; R7 gets the incremented PC.
          OP_JSR: begin
            c.rf_w_en       = 1'b1;
            c.rf_w_addr_sel = 1'b1;
            c.rf_w_data_sel = 2'd2;
            c.pc_ld         = 1'b1;
            c.pc_ld_sel     = i[11] ? 2'd1 : 2'd2;
          end
          default: ;
        endcase
      end
      IND: begin
        c.mem_addr_sel = 2'd3;
        if (i[15:12] == OP_STI) begin
          c.rf_r0_addr_sel = 1'b1;
          c.mem_w_en       = 1'b1;
        end else begin
          c.rf_w_data_sel = 2'd1;
          c.rf_w_en       = 1'b1;
        end
      end
      HALT:    c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = state;
    case (state)
      INIT:    nxt = FETCH;
      FETCH:   nxt = DECODE;
      DECODE:  nxt = (op == OP_TRP) ? HALT : EXEC;
      EXEC:    nxt = (op == OP_LDI || op == OP_STI) ? IND : FETCH;
      IND:     nxt = FETCH;
      HALT:    nxt = HALT;
      default: nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= INIT;
      ctrl        <= '0;
      ctrl.pc_clr <= 1'b1;
      nzp         <= RESET_NZP;
    end else begin
      state <= nxt;
      ctrl  <= dec(nxt, ir, nzp);
      if (ctrl.rf_w_en && !ctrl.rf_w_addr_sel)
        nzp <= {rf_w_data[15],
                rf_w_data == 16'h0000,
                !rf_w_data[15] && rf_w_data != 16'h0000};
    end
  end

  assign ir_ld          = ctrl.ir_ld;
  assign pc_clr         = ctrl.pc_clr;
  assign pc_inc         = ctrl.pc_inc;
  assign pc_ld          = ctrl.pc_ld;
  assign pc_ld_sel      = ctrl.pc_ld_sel;
  assign mem_addr_sel   = ctrl.mem_addr_sel;
  assign ind_ld         = ctrl.ind_ld;
  assign mem_w_en       = ctrl.mem_w_en;
  assign rf_w_en        = ctrl.rf_w_en;
  assign rf_w_addr_sel  = ctrl.rf_w_addr_sel;
  assign rf_w_data_sel  = ctrl.rf_w_data_sel;
  assign rf_r0_addr_sel = ctrl.rf_r0_addr_sel;
  assign rf_r1_addr_sel = ctrl.rf_r1_addr_sel;
  assign alu_sel        = ctrl.alu_sel;
  assign halted         = ctrl.halted;

endmodule
